// File: rtl/adc_ctrl_pkg.sv
// Shared types and timing helpers for the L0 summing-engine controller.
package adc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE,
        HOLD
    } ctrl_state_t;

    typedef struct packed {
        logic [15:0] evid;
        logic [11:0] sum;
    } sum_result_t;

    // Cycles from the engine start pulse until its result is stable on data_out.
    function automatic int unsigned done_lat(input int unsigned presample,
                                             input int unsigned sample);
        return presample + sample + 2;
    endfunction

endpackage

// File: rtl/sum_result_fifo.sv
// Synchronous first-word-fall-through FIFO of tagged sum results.
// When empty, the head output keeps the most recently popped entry.
module sum_result_fifo
    import adc_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  sum_result_t wr_data,
    input  logic        pop,
    output sum_result_t rd_data,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    sum_result_t last_q, last_d;
    sum_result_t mem_q [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_ok   = pop && !empty;
        // A pop frees the slot in the same cycle, so a push on full is still taken.
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        last_d   = pop_ok  ? mem_q[rd_ptr_q[AW-1:0]] : last_q;
        rd_data  = empty   ? last_q : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/l0_sum_ctrl.sv
// L0 trigger qualifier and sequencer for one presample/sample summing engine;
// captures the engine result at its fixed completion cycle and queues it with an event ID.
module l0_sum_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int unsigned PRESAMPLE_NUM = 8,
    parameter int unsigned SAMPLE_NUM    = 24,
    parameter int unsigned HOLDOFF       = 4,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        l0_in,
    output logic        l0_out,
    input  logic [11:0] sum_in,
    output logic        busy,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [11:0] res_sum,
    output logic [15:0] res_evid,
    output logic [15:0] rej_cnt,
    output logic [15:0] drop_cnt
);

    localparam int unsigned DONE_LAT = done_lat(PRESAMPLE_NUM, SAMPLE_NUM);

    ctrl_state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] evid_q, evid_d;
    logic [15:0] rej_cnt_q, rej_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        l0_out_q, l0_out_d;
    logic        accept;
    logic        capture;
    logic        rej_evt;
    logic        drop_evt;
    logic        fifo_full;
    logic        fifo_empty;
    sum_result_t fifo_wr;
    sum_result_t fifo_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            evid_q     <= '0;
            rej_cnt_q  <= '0;
            drop_cnt_q <= '0;
            l0_out_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            evid_q     <= evid_d;
            rej_cnt_q  <= rej_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            l0_out_q   <= l0_out_d;
        end
    end

    // Counter loads N-1 so the state spends exactly N cycles in WAIT/HOLD.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (l0_in && enable) begin
                    state_d = WAIT;
                    cnt_d   = 16'(DONE_LAT - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            CAPTURE: begin
                if (HOLDOFF > 0) begin
                    state_d = HOLD;
                    cnt_d   = 16'(HOLDOFF - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept   = (state_q == IDLE) && l0_in && enable;
        capture  = (state_q == CAPTURE);
        rej_evt  = l0_in && !accept;
        drop_evt = capture && fifo_full && !res_ready;
        busy     = (state_q != IDLE);
        l0_out_d = accept;
        fifo_wr  = '{evid: evid_q, sum: sum_in};
        evid_d   = capture ? evid_q + 16'd1 : evid_q;

        rej_cnt_d = rej_cnt_q;
        if (rej_evt && (rej_cnt_q != '1)) begin
            rej_cnt_d = rej_cnt_q + 16'd1;
        end
        drop_cnt_d = drop_cnt_q;
        if (drop_evt && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    sum_result_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (capture),
        .wr_data(fifo_wr),
        .pop    (res_ready),
        .rd_data(fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign l0_out    = l0_out_q;
    assign res_valid = !fifo_empty;
    assign res_sum   = fifo_head.sum;
    assign res_evid  = fifo_head.evid;
    assign rej_cnt   = rej_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
